// File: rtl/action_sequencer.sv
// Frame-timed arbiter for hit stun / attack / dodge / shield; outputs registered, updated on the transition edge.
// No backpressure: inputs are sampled every cycle, button logic acts only on frame_tick, hits act on any cycle.
module action_sequencer #(
    parameter int ATK_STARTUP    = 3,
    parameter int ATK_ACTIVE     = 4,
    parameter int ATK_RECOVERY   = 6,
    parameter int DODGE_FRAMES   = 8,
    parameter int DODGE_COOLDOWN = 10,
    parameter int HITSTUN_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 grounded,
    input  logic                 btn_atk,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 hit_valid,
    input  logic [HITSTUN_W-1:0] hit_stun,
    output logic                 hit_stun_active,
    output logic                 attack_active,
    output logic                 attack_hitbox,
    output logic                 dodge_active,
    output logic                 shield_active,
    output logic [2:0]           state_code
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ATK_START = 3'd1,
        S_ATK_HIT   = 3'd2,
        S_ATK_REC   = 3'd3,
        S_DODGE     = 3'd4,
        S_SHIELD    = 3'd5,
        S_HITSTUN   = 3'd6
    } state_t;

    localparam logic [7:0] STARTUP_F  = 8'(ATK_STARTUP);
    localparam logic [7:0] ACTIVE_F   = 8'(ATK_ACTIVE);
    localparam logic [7:0] RECOVERY_F = 8'(ATK_RECOVERY);
    localparam logic [7:0] DODGE_F    = 8'(DODGE_FRAMES);
    localparam logic [7:0] COOLDOWN_F = 8'(DODGE_COOLDOWN);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] cooldown, cooldown_nxt;
    logic       air_dodge_used, air_nxt;
    logic       prev_atk, prev_down;

    logic       atk_edge, down_edge, dodge_ok, shield_req;
    logic       hit_take, expiring, go_dodge;
    logic [7:0] stun_full, stun_eff;

    always_comb begin
        atk_edge   = btn_atk & ~prev_atk;
        down_edge  = btn_down & ~prev_down;
        // Grounded rolls need a direction; air dodges only need the down edge but are one per airtime.
        dodge_ok   = down_edge & (~grounded | btn_left | btn_right) &
                     (cooldown == 8'd0) & (grounded | ~air_dodge_used);
        shield_req = btn_down & grounded & ~btn_left & ~btn_right;
        stun_full  = 8'(hit_stun);
        stun_eff   = (state == S_SHIELD) ? (stun_full >> 1) : stun_full;
        hit_take   = hit_valid & (stun_full != 8'd0) & (state != S_DODGE);
        expiring   = (cnt <= 8'd1);
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cooldown_nxt = cooldown;
        air_nxt      = air_dodge_used;
        go_dodge     = 1'b0;

        if (frame_tick) begin
            if (cooldown != 8'd0) cooldown_nxt = cooldown - 8'd1;
            if (grounded)         air_nxt      = 1'b0;
        end

        if (hit_take) begin
            // A shielded hit that halves to zero is fully absorbed.
            if (stun_eff != 8'd0) begin
                state_nxt = S_HITSTUN;
                cnt_nxt   = stun_eff;
            end
        end else if (frame_tick) begin
            case (state)
                S_IDLE: begin
                    if (dodge_ok) begin
                        go_dodge = 1'b1;
                    end else if (atk_edge) begin
                        state_nxt = S_ATK_START;
                        cnt_nxt   = STARTUP_F;
                    end else if (shield_req) begin
                        state_nxt = S_SHIELD;
                    end
                end
                S_SHIELD: begin
                    if (dodge_ok)                  go_dodge  = 1'b1;
                    else if (!btn_down || !grounded) state_nxt = S_IDLE;
                end
                S_ATK_START: begin
                    if (expiring) begin
                        state_nxt = S_ATK_HIT;
                        cnt_nxt   = ACTIVE_F;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_ATK_HIT: begin
                    if (expiring) begin
                        state_nxt = S_ATK_REC;
                        cnt_nxt   = RECOVERY_F;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_DODGE: begin
                    if (expiring) begin
                        state_nxt    = S_IDLE;
                        cnt_nxt      = 8'd0;
                        cooldown_nxt = COOLDOWN_F;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_ATK_REC, S_HITSTUN: begin
                    if (expiring) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase

            if (go_dodge) begin
                state_nxt = S_DODGE;
                cnt_nxt   = DODGE_F;
                if (!grounded) air_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= 8'd0;
            cooldown        <= 8'd0;
            air_dodge_used  <= 1'b0;
            prev_atk        <= 1'b0;
            prev_down       <= 1'b0;
            state_code      <= 3'd0;
            hit_stun_active <= 1'b0;
            attack_active   <= 1'b0;
            attack_hitbox   <= 1'b0;
            dodge_active    <= 1'b0;
            shield_active   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            cooldown       <= cooldown_nxt;
            air_dodge_used <= air_nxt;
            if (frame_tick) begin
                prev_atk  <= btn_atk;
                prev_down <= btn_down;
            end
            state_code      <= state_nxt;
            hit_stun_active <= (state_nxt == S_HITSTUN);
            attack_active   <= (state_nxt == S_ATK_START) || (state_nxt == S_ATK_HIT) ||
                               (state_nxt == S_ATK_REC);
            attack_hitbox   <= (state_nxt == S_ATK_HIT);
            dodge_active    <= (state_nxt == S_DODGE);
            shield_active   <= (state_nxt == S_SHIELD);
        end
    end

endmodule
